// File: rtl/qlog2_pkg.sv
// Shared types and helpers for the qlog2_seq repeated-squaring base-2 logarithm unit.
package qlog2_pkg;

    // Widest input word the leading-one search supports.
    localparam int unsigned MAX_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        SQUARE,
        DONE
    } state_e;

    function automatic int unsigned res_w(input int unsigned width, input int unsigned out_frac);
        return $clog2(width) + 1 + out_frac;
    endfunction

    // Index of the most significant set bit; 0 for an all-zero word.
    function automatic int unsigned lead_one(input logic [MAX_W-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/qsquare.sv
// Combinational unsigned squarer: WIDTH-bit operand, full 2*WIDTH-bit product.
module qsquare #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    output logic [2*WIDTH-1:0] p
);

    logic [2*WIDTH-1:0] a_ext;

    always_comb begin
        a_ext = {{WIDTH{1'b0}}, a};
        p     = a_ext * a_ext;
    end

endmodule

// File: rtl/qlog2_seq.sv
// Sequential unsigned fixed-point log2 via leading-one normalisation plus one squaring per fraction bit.
// Define QLOG2_ROUND_EN for a guard-bit iteration with round-half-up and positive saturation.
module qlog2_seq
    import qlog2_pkg::*;
#(
    parameter  int unsigned WIDTH    = 32,
    parameter  int unsigned FRAC     = 16,
    parameter  int unsigned OUT_FRAC = 16,
    localparam int unsigned RES_W    = res_w(WIDTH, OUT_FRAC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_log,
    output logic             out_err
);

    localparam int unsigned INT_W = $clog2(WIDTH) + 1;
`ifdef QLOG2_ROUND_EN
    localparam int unsigned FB = OUT_FRAC + 1;
`else
    localparam int unsigned FB = OUT_FRAC;
`endif
    localparam int unsigned CNT_W = $clog2(FB + 1);
    localparam logic [RES_W-1:0] RES_MIN = {1'b1, {(RES_W-1){1'b0}}};
`ifdef QLOG2_ROUND_EN
    localparam logic [RES_W-1:0] RES_MAX = {1'b0, {(RES_W-1){1'b1}}};
`endif

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [INT_W-1:0]   n_q, n_d;
    logic [FB-1:0]      frac_q, frac_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RES_W-1:0]   log_q, log_d;
    logic               err_q, err_d;

    logic [2*WIDTH-1:0] sq_p;
    logic               sq_bit;
    int unsigned        lead;
`ifdef QLOG2_ROUND_EN
    logic [RES_W-1:0]   trunc;
`endif
    logic               unused_sq;

    qsquare #(.WIDTH(WIDTH)) u_sq (
        .a (m_q),
        .p (sq_p)
    );

    assign unused_sq = ^sq_p[WIDTH-2:0];

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        n_d     = n_q;
        frac_d  = frac_q;
        cnt_d   = cnt_q;
        log_d   = log_q;
        err_d   = err_q;
        lead    = lead_one(MAX_W'(m_q));
        sq_bit  = sq_p[2*WIDTH-1];
`ifdef QLOG2_ROUND_EN
        trunc   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = in_x;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (m_q == '0) begin
                    err_d   = 1'b1;
                    log_d   = RES_MIN;
                    state_d = DONE;
                end else begin
                    err_d   = 1'b0;
                    n_d     = INT_W'(int'(lead) - int'(FRAC));
                    m_d     = m_q << (WIDTH - 1 - lead);
                    frac_d  = '0;
                    cnt_d   = '0;
                    state_d = SQUARE;
                end
            end
            SQUARE: begin
                // Square >= 2 means the fraction bit is 1; renormalise back into [1,2).
                frac_d = (frac_q << 1) | FB'(sq_bit);
                m_d    = sq_bit ? sq_p[2*WIDTH-1:WIDTH] : sq_p[2*WIDTH-2:WIDTH-1];
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(FB - 1)) begin
                    state_d = DONE;
`ifdef QLOG2_ROUND_EN
                    trunc = {n_q, frac_d[FB-1:1]};
                    if (frac_d[0] && (trunc == RES_MAX)) begin
                        log_d = RES_MAX;
                    end else begin
                        log_d = trunc + RES_W'(frac_d[0]);
                    end
`else
                    log_d = {n_q, frac_d};
`endif
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            n_q     <= '0;
            frac_q  <= '0;
            cnt_q   <= '0;
            log_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            n_q     <= n_d;
            frac_q  <= frac_d;
            cnt_q   <= cnt_d;
            log_q   <= log_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_log   = log_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_qlog2_seq.sv
// Directed self-checking bench for qlog2_seq at default parameters (RES_W = 22).
module tb_qlog2_seq;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned FRAC     = 16;
    localparam int unsigned OUT_FRAC = 16;
    localparam int unsigned RES_W    = 22;
`ifdef QLOG2_ROUND_EN
    localparam int LAT = 19;
`else
    localparam int LAT = 18;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_log;
    logic             out_err;

    int vectors    = 0;
    int miscompares = 0;

    qlog2_seq #(
        .WIDTH    (WIDTH),
        .FRAC     (FRAC),
        .OUT_FRAC (OUT_FRAC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_log   (out_log),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction: accept x, measure latency, check result, optionally stall the consumer.
    task automatic xact(input string tag, input logic [31:0] x, input logic [21:0] exp_log,
                        input logic exp_err, input int exp_lat, input bit approx, input int hold);
        int  cyc;
        bit  seen;
        int  diff;
        logic [21:0] held;
        @(negedge clk);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_x     = x;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                cyc++;
            end
        end
        check({tag, "_lat"}, 32'(cyc + 1), 32'(exp_lat));
        if (approx) begin
            diff = int'(out_log) - int'(exp_log);
            check({tag, "_log_pm1"}, 32'((diff >= -1) && (diff <= 1)), 32'd1);
        end else begin
            check({tag, "_log"}, 32'(out_log), 32'(exp_log));
        end
        check({tag, "_err"}, 32'(out_err), 32'(exp_err));
        held = out_log;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_log"}, 32'(out_log), 32'(held));
            check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_x      = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_log", 32'(out_log), 32'd0);
        check("rst_err", 32'(out_err), 32'd0);

        xact("one",    32'h0001_0000, 22'h000000, 1'b0, LAT, 1'b0, 0);
        xact("four",   32'h0004_0000, 22'h020000, 1'b0, LAT, 1'b0, 0);
        xact("p2_15",  32'h8000_0000, 22'h0F0000, 1'b0, LAT, 1'b0, 0);
        xact("half",   32'h0000_8000, 22'h3F0000, 1'b0, LAT, 1'b0, 0);
        xact("lsb",    32'h0000_0001, 22'h300000, 1'b0, LAT, 1'b0, 0);
        xact("zero",   32'h0000_0000, 22'h200000, 1'b1, 2,   1'b0, 0);
        // log2(1.875) * 65536 = 59433.98 -> 59433 = 16'hE829
        xact("x1_875", 32'h0001_E000, 22'h00E829, 1'b0, LAT, 1'b1, 5);

        // Abort mid-SQUARE with a one-cycle reset.
        @(negedge clk);
        in_x     = 32'h0001_E000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);

        xact("two", 32'h0002_0000, 22'h010000, 1'b0, LAT, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
